// File: rtl/stack_mac_drain.sv
// Drains replicated operand A from the stack's show-ahead port, pairs it with a
// B stream, and accumulates a signed dot product of cfg_len terms per job.
//
// state | meaning
// IDLE  | waiting for start with a non-zero length
// RUN   | issuing one term per cycle when stack and B are both available
// FLUSH | last term in the product stage, result loads next edge
// OUT   | result held on res_data/res_valid until accepted
module stack_mac_drain #(
   parameter int A_W   = 32,
   parameter int B_W   = 16,
   parameter int ACC_W = 48,
   parameter int LEN_W = 16,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             abort,
   input  logic [A_W-1:0]   fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rden,
   input  logic [B_W-1:0]   b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   localparam int P_W = A_W + B_W;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        issued_q, issued_d;
   logic signed [P_W-1:0]   prod_q;
   logic                    prod_vld_q;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [ACC_W-1:0]        res_q, res_d;
   logic                    res_vld_q, res_vld_d;

   logic                    fire;
   logic signed [P_W-1:0]   prod_w;
   logic signed [ACC_W-1:0] prod_ext;
   logic [ACC_W:0]          sum_w;
   logic                    ovf;
   logic [ACC_W-1:0]        acc_sum;

   // Gating on !fifo_empty keeps a pop from ever reaching an empty stack.
   assign fire = (state_q == S_RUN) && !abort && !fifo_empty && b_valid
                 && (issued_q < len_q);

   assign prod_w = P_W'($signed(fifo_dout)) * P_W'($signed(b_data));

   assign prod_ext = ACC_W'(prod_q);
   assign sum_w    = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
   assign ovf      = sum_w[ACC_W] ^ sum_w[ACC_W-1];

   always_comb begin
      acc_sum = sum_w[ACC_W-1:0];
      if (SAT && ovf) begin
         acc_sum = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
      end else begin
         prod_vld_q <= fire;
         if (fire) begin
            prod_q <= prod_w;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         issued_q  <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         issued_q  <= issued_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      issued_d  = issued_q;
      acc_d     = acc_q;
      res_d     = res_q;
      res_vld_d = res_vld_q;

      if (prod_vld_q) begin
         acc_d = acc_sum;
      end

      case (state_q)
         S_IDLE: begin
            if (start && (cfg_len != '0)) begin
               len_d    = cfg_len;
               issued_d = '0;
               acc_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (fire) begin
               issued_d = issued_q + 1'b1;
               if ((issued_q + 1'b1) == len_q) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // The last product is in stage 1; take the sum it is about to form.
            if (prod_vld_q) begin
               res_d     = acc_sum;
               res_vld_d = 1'b1;
               state_d   = S_OUT;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               res_vld_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         res_vld_d = 1'b0;
         state_d   = S_IDLE;
      end
   end

   assign fifo_rden = fire;
   assign b_ready   = fire;
   assign res_data  = res_q;
   assign res_valid = res_vld_q && !abort;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_stack_mac_drain.sv
// Randomized bench for stack_mac_drain: queue-backed stack and B sources, with
// the expected dot product computed directly from the queued operands.
module tb_stack_mac_drain;

   localparam int A_W   = 32;
   localparam int B_W   = 16;
   localparam int ACC_W = 48;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] cfg_len;
   logic             abort;
   logic [A_W-1:0]   fifo_dout;
   logic             fifo_empty;
   logic             fifo_rden;
   logic [B_W-1:0]   b_data;
   logic             b_valid;
   logic             b_ready;
   logic [ACC_W-1:0] res_data;
   logic             res_valid;
   logic             res_ready;
   logic             busy;

   logic       s_start, s_rr;
   logic [3:0] s_len;
   logic [7:0] s_a, s_b;
   logic       sat_rden, sat_bready, sat_vld, sat_busy;
   logic       wrp_rden, wrp_bready, wrp_vld, wrp_busy;
   logic [7:0] sat_res, wrp_res;

   stack_mac_drain #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SAT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
   );

   stack_mac_drain #(.A_W(8), .B_W(8), .ACC_W(8), .LEN_W(4), .SAT(1'b1)) u_sat (
      .clk(clk), .rst(rst), .start(s_start), .cfg_len(s_len), .abort(1'b0),
      .fifo_dout(s_a), .fifo_empty(1'b0), .fifo_rden(sat_rden),
      .b_data(s_b), .b_valid(1'b1), .b_ready(sat_bready),
      .res_data(sat_res), .res_valid(sat_vld), .res_ready(s_rr), .busy(sat_busy)
   );

   stack_mac_drain #(.A_W(8), .B_W(8), .ACC_W(8), .LEN_W(4), .SAT(1'b0)) u_wrp (
      .clk(clk), .rst(rst), .start(s_start), .cfg_len(s_len), .abort(1'b0),
      .fifo_dout(s_a), .fifo_empty(1'b0), .fifo_rden(wrp_rden),
      .b_data(s_b), .b_valid(1'b1), .b_ready(wrp_bready),
      .res_data(wrp_res), .res_valid(wrp_vld), .res_ready(s_rr), .busy(wrp_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   logic signed [A_W-1:0] qa[$];
   logic signed [B_W-1:0] qb[$];
   int pops, bcons, last_fire, viol;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: continuous; 1: random gaps; 2: empty every other cycle, B low k=2,3
   task automatic drive(input int mode, input int k);
      bit ga, gb;
      ga = 1'b0;
      gb = 1'b0;
      if (mode == 1) begin
         ga = ($urandom_range(0, 2) == 0);
         gb = ($urandom_range(0, 2) == 0);
      end else if (mode == 2) begin
         ga = (k % 2 == 1);
         gb = (k == 2 || k == 3);
      end
      fifo_empty = (qa.size() == 0) || ga;
      fifo_dout  = fifo_empty ? A_W'($urandom) : qa[0];
      b_valid    = (qb.size() != 0) && !gb;
      b_data     = b_valid ? qb[0] : B_W'($urandom);
   endtask

   task automatic sample();
      @(negedge clk);
      if (fifo_rden) begin
         pops++;
         last_fire = cyc;
         if (fifo_empty) viol++;
         if (qa.size() != 0) void'(qa.pop_front());
      end
      if (b_ready) begin
         bcons++;
         if (!b_valid) viol++;
         if (qb.size() != 0) void'(qb.pop_front());
      end
      if (fifo_rden !== b_ready) viol++;
   endtask

   task automatic adv(input int mode, input int k);
      @(posedge clk);
      #1;
      drive(mode, k);
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n + 2; i++) begin
         qa.push_back(A_W'($urandom));
         qb.push_back(B_W'($urandom));
      end
   endtask

   task automatic clear_src();
      qa.delete();
      qb.delete();
      drive(0, 0);
   endtask

   // out_mode 0: accept at once; 1: hold 5 cycles with a stray start; 2: abort in OUT
   task automatic run_job(input string nm, input int len, input int mode, input int out_mode);
      logic [ACC_W-1:0] e;
      bit got;
      int sb;
      e = '0;
      for (int i = 0; i < len; i++) begin
         e = e + ACC_W'(longint'(qa[i]) * longint'(qb[i]));
      end
      @(posedge clk);
      #1;
      pops = 0; bcons = 0; viol = 0;
      start = 1'b1;
      cfg_len = LEN_W'(len);
      drive(mode, 0);
      sample();
      adv(mode, 0);
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 400; k++) begin
         sample();
         if (k == 0) check({nm, "_busy_run"}, 64'(busy), 64'd1);
         if (res_valid) begin
            got = 1'b1;
            break;
         end
         adv(mode, k + 1);
      end
      check({nm, "_res_seen"}, 64'(got), 64'd1);
      check({nm, "_latency"}, 64'(cyc - last_fire), 64'd2);
      check({nm, "_pops"}, 64'(pops), 64'(len));
      check({nm, "_b_used"}, 64'(bcons), 64'(len));
      check({nm, "_res_data"}, 64'(res_data), 64'(e));
      check({nm, "_handshake"}, 64'(viol), 64'd0);
      if (out_mode == 2) begin
         adv(mode, 99);
         abort = 1'b1;
         #1;
         check({nm, "_abort_out_valid"}, 64'(res_valid), 64'd0);
         sample();
         adv(mode, 99);
         abort = 1'b0;
         sample();
         check({nm, "_abort_out_idle"}, 64'(busy), 64'd0);
      end else begin
         if (out_mode == 1) begin
            sb = 0;
            for (int i = 0; i < 5; i++) begin
               adv(mode, 99);
               res_ready = 1'b0;
               start = (i == 2);
               cfg_len = LEN_W'(3);
               sample();
               if (res_valid !== 1'b1 || res_data !== e) sb++;
            end
            start = 1'b0;
            check({nm, "_out_hold"}, 64'(sb), 64'd0);
         end
         adv(mode, 99);
         res_ready = 1'b1;
         sample();
         check({nm, "_accept_valid"}, 64'(res_valid), 64'd1);
         check({nm, "_accept_busy"}, 64'(busy), 64'd1);
         adv(mode, 99);
         res_ready = 1'b0;
         sample();
         check({nm, "_valid_drop"}, 64'(res_valid), 64'd0);
         check({nm, "_busy_idle"}, 64'(busy), 64'd0);
      end
      check({nm, "_no_extra_pop"}, 64'(pops), 64'(len));
      clear_src();
   endtask

   task automatic small_job(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] e_sat, input logic [7:0] e_wrp);
      bit got;
      @(posedge clk);
      #1;
      s_a = a;
      s_b = b;
      s_len = 4'd2;
      s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sat_vld && wrp_vld) begin
            got = 1'b1;
            break;
         end
      end
      check({nm, "_seen"}, 64'(got), 64'd1);
      check({nm, "_sat"}, 64'(sat_res), 64'(e_sat));
      check({nm, "_wrap"}, 64'(wrp_res), 64'(e_wrp));
      @(posedge clk);
      #1;
      s_rr = 1'b1;
      @(posedge clk);
      #1;
      s_rr = 1'b0;
   endtask

   initial begin
      bit got;
      rst = 1'b1; start = 1'b0; cfg_len = '0; abort = 1'b0; res_ready = 1'b0;
      s_start = 1'b0; s_rr = 1'b0; s_len = '0; s_a = '0; s_b = '0;
      pops = 0; bcons = 0; viol = 0; last_fire = 0;
      drive(0, 0);
      #1;
      check("rst_rden", 64'(fifo_rden), 64'd0);
      check("rst_bready", 64'(b_ready), 64'd0);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_data", 64'(res_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // zero-length start must be ignored
      @(posedge clk);
      #1;
      start = 1'b1;
      cfg_len = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("len0_ignored", 64'(busy), 64'd0);

      // A=3 replicated four times, B=1..4, extra distinct entries behind them
      for (int i = 0; i < 4; i++) begin
         qa.push_back(A_W'(3));
         qb.push_back(B_W'(i + 1));
      end
      qa.push_back(A_W'(7)); qb.push_back(B_W'(9));
      qa.push_back(A_W'(7)); qb.push_back(B_W'(9));
      run_job("dot4", 4, 0, 0);

      qa.push_back(-A_W'(2)); qb.push_back(B_W'(5));
      qa.push_back(A_W'(11)); qb.push_back(B_W'(13));
      run_job("neg1", 1, 0, 0);

      load_rand(3);
      run_job("gaps3", 3, 2, 1);

      load_rand(5);
      run_job("after_hold", 5, 1, 0);

      for (int j = 0; j < 6; j++) begin
         int len;
         len = $urandom_range(1, 12);
         load_rand(len);
         run_job("rand", len, (j % 2 == 0) ? 1 : 0, 0);
      end

      load_rand(4);
      run_job("abort_out", 4, 0, 2);

      // reset in the middle of RUN after two terms
      load_rand(4);
      @(posedge clk);
      #1;
      pops = 0;
      start = 1'b1;
      cfg_len = LEN_W'(4);
      drive(0, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         sample();
         if (pops == 2) begin
            got = 1'b1;
            break;
         end
         adv(0, k + 1);
      end
      check("mid_rst_reached", 64'(got), 64'd1);
      adv(0, 9);
      rst = 1'b1;
      #1;
      check("mid_rst_rden", 64'(fifo_rden), 64'd0);
      check("mid_rst_bready", 64'(b_ready), 64'd0);
      check("mid_rst_valid", 64'(res_valid), 64'd0);
      check("mid_rst_data", 64'(res_data), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_src();
      for (int i = 0; i < 4; i++) begin
         qa.push_back(A_W'(1));
         qb.push_back(B_W'(1));
      end
      run_job("post_rst", 2, 0, 0);

      // abort during FLUSH
      load_rand(3);
      @(posedge clk);
      #1;
      pops = 0;
      start = 1'b1;
      cfg_len = LEN_W'(3);
      drive(0, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         sample();
         if (pops == 3) begin
            got = 1'b1;
            break;
         end
         adv(0, k + 1);
      end
      check("flush_reached", 64'(got), 64'd1);
      adv(0, 9);
      abort = 1'b1;
      #1;
      check("abort_flush_busy", 64'(busy), 64'd1);
      check("abort_flush_rden", 64'(fifo_rden), 64'd0);
      sample();
      adv(0, 9);
      abort = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample();
         if (res_valid || busy) got = 1'b1;
         adv(0, 9);
      end
      check("abort_flush_no_res", 64'(got), 64'd0);
      check("abort_flush_pops", 64'(pops), 64'd3);
      clear_src();
      load_rand(6);
      run_job("post_abort", 6, 1, 0);

      // narrow instances: 10*10 twice, then -12*10 twice
      small_job("sat_pos", 8'd10, 8'd10, 8'h7F, 8'hC8);
      small_job("sat_neg", 8'hF4, 8'd10, 8'h80, 8'h10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/stack_mac_drain.md
Name: stack_mac_drain

Overview:
- Downstream consumer of the repeat-FIFO stack that feeds the MAC array.
- Pops one replicated operand A per term from the stack's show-ahead read port and pairs it with operand B from a valid/ready stream.
- Multiplies signed A×B and accumulates a programmed number of terms.
- Presents one dot-product result per job on a valid/ready output.

Parameters:
- A_W, 32, operand A width (matches stack data width)
- B_W, 16, operand B width
- ACC_W, 48, accumulator/result width (≥ A_W+B_W)
- LEN_W, 16, term-count width
- SAT, 0, 1 = saturating accumulate, 0 = wrap modulo 2^ACC_W

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  job start pulse, sampled only in IDLE
- cfg_len  in  LEN_W  terms per job, sampled with start
- abort  in  1  synchronous job cancel
- fifo_dout  in  A_W  stack head data, valid when fifo_empty=0
- fifo_empty  in  1  stack empty flag
- fifo_rden  out  1  stack pop (consumes one replica)
- b_data  in  B_W  operand B
- b_valid  in  1  B valid
- b_ready  out  1  B ready
- res_data  out  ACC_W  accumulated result
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; fifo_rden=0, b_ready=0, res_valid=0, res_data=0, busy=0; counters, pipeline valids and accumulator cleared.
- Reset mid-job: job discarded, no result emitted.
- FSM states: IDLE, RUN, FLUSH, OUT.
- IDLE:
  - start=1 and cfg_len≠0 → latch len, clear accumulator and issue count, go to RUN.
  - start with cfg_len=0 is ignored; stay IDLE.
- RUN:
  - fire = !fifo_empty & b_valid & (issued < len).
  - fifo_rden = b_ready = fire, combinational, so a pop only occurs when the stack is non-empty.
  - Each fire captures fifo_dout and b_data into the product stage and increments issued.
  - Gaps on either side simply stall; no pop or handshake occurs that cycle.
  - When the fire with issued=len-1 occurs, go to FLUSH.
- Pipeline:
  - Stage 1 registers the signed product (A_W+B_W bits).
  - Stage 2 sign-extends the product to ACC_W and adds it to the accumulator.
  - SAT=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on overflow. SAT=0: wrap.
- FLUSH:
  - Wait until both pipeline stages drain, exactly 2 cycles after the last fire.
  - Then load res_data from the accumulator, set res_valid=1, go to OUT.
- Timing: last fire in cycle T → res_valid=1 in cycle T+2.
- OUT:
  - res_data and res_valid are held stable until res_ready=1.
  - On acceptance: res_valid=0 the next cycle, go to IDLE.
  - start is ignored in OUT; start can first be accepted the cycle after res_valid drops.
- abort=1 in RUN, FLUSH or OUT:
  - Next state IDLE; res_valid=0, fifo_rden=0, b_ready=0 that same cycle; pipeline valids cleared.
  - abort in IDLE has no effect.
  - abort wins over start and over res_ready.
- Ownership: the stack decides replica repetition; this block counts pops only. One fire = one term regardless of replica index.
- Throughput: one term per cycle when both sources are continuously available.

Test Plan:
- Stack holds A=3 with dnum=4; B=1,2,3,4 continuous; start, cfg_len=4 → exactly 4 fifo_rden pulses; res_valid 2 cycles after the 4th fire; res_data=30.
- A=-2, B=5, cfg_len=1 → res_data = -10 (sign-extended to ACC_W); busy high from the cycle after start until the cycle after acceptance.
- cfg_len=3, fifo_empty toggles every other cycle, b_valid held low for 2 cycles mid-job → no fifo_rden while empty; exactly 3 fires; correct sum; no extra B consumed.
- Result ready, res_ready low for 5 cycles → res_data/res_valid stable throughout; start pulsed during OUT is ignored; a new start after acceptance succeeds.
- ACC_W=8, A_W=B_W=8, products 100 and 100: SAT=1 → 127; SAT=0 → -56.
- rst asserted mid-RUN after 2 of 4 terms → all outputs 0 immediately; after release, a new job of A=1, B=1, len=2 yields 2. Also: abort in FLUSH → no result; next job correct.
